// File: rtl/recip_div_unit.sv
// Multi-cycle restoring divider: result = round(num * 2^frac / den) with
// half-LSB-up rounding and saturation to all ones on den==0 or overflow.
module recip_div_unit #(
    parameter int NUM_W    = 16,
    parameter int DEN_W    = 16,
    parameter int OUT_W    = 24,
    parameter int FRAC_MAX = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic [4:0]       frac,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);
    localparam int ITER  = NUM_W + FRAC_MAX + 1;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [ITER-1:0]    x_q, x_d;
    logic [ITER-1:0]    q_q, q_d;
    logic [DEN_W-1:0]   r_q, r_d;
    logic [DEN_W-1:0]   den_q, den_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;

    logic [4:0]         frac_c;
    logic [5:0]         shamt;
    logic [DEN_W:0]     r_shift;
    logic               ge;
    logic [DEN_W-1:0]   r_sub;
    logic [ITER:0]      t;
    logic               big;

    always_comb begin
        frac_c  = (frac > 5'(FRAC_MAX)) ? 5'(FRAC_MAX) : frac;
        shamt   = {1'b0, frac_c} + 6'd1;
        // The remainder stays below den, so one extra bit holds the shifted value.
        r_shift = {r_q, x_q[ITER-1]};
        ge      = (r_shift >= {1'b0, den_q});
        r_sub   = r_shift[DEN_W-1:0] - den_q;
        // Q carries one extra fraction bit; adding it back rounds half up.
        t       = (ITER+1)'(q_q >> 1) + (ITER+1)'(q_q[0]);
        big     = |(t >> OUT_W);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        q_d      = q_q;
        r_d      = r_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    den_d   = den;
                    x_d     = ITER'(num) << shamt;
                    q_d     = '0;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    sat_d   = (den == '0);
                    state_d = (den == '0) ? ROUND : RUN;
                end
            end
            RUN: begin
                r_d   = ge ? r_sub : r_shift[DEN_W-1:0];
                q_d   = {q_q[ITER-2:0], ge};
                x_d   = x_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (sat_q || big) begin
                    result_d = '1;
                    ovf_d    = 1'b1;
                end else begin
                    result_d = t[OUT_W-1:0];
                    ovf_d    = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            q_q      <= q_d;
            r_q      <= r_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
endmodule

// File: doc/recip_div_unit.md
Name: recip_div_unit

Overview:
- Multi-cycle restoring divider with half-LSB-up rounding and saturation. It is the arithmetic coprocessor the TopLevel datapath calls for the reciprocal (1/x) and 16/8 division programs.
- The processor loads operands from data memory and pulses start. It stalls on busy and writes result back to data memory on done.
- Computes result = round(num × 2^frac / den), rounding exactly as the bench models do: truncated quotient plus the next quotient bit.

Parameters:
- NUM_W, 16, numerator width
- DEN_W, 16, divisor width; 8-bit divisors are zero-extended by the caller
- OUT_W, 24, result width; instantiate with 16 for the reciprocal program
- FRAC_MAX, 16, largest legal frac value

Ports:
- CLK  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- num  in  NUM_W  numerator
- den  in  DEN_W  divisor
- frac  in  5  left shift applied to num; values above FRAC_MAX clamp to FRAC_MAX
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- result  out  OUT_W  rounded quotient; holds until the next accepted start
- ovf  out  1  set when result saturated (den==0 or too large); held with result

Behaviour:
- Reset (async, Reset_n low):
  - state=IDLE; busy=0, done=0, result=0, ovf=0.
  - Internal remainder, quotient, dividend and counter registers cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, ROUND, DONE.
- IDLE:
  - When start=1 at a rising edge, latch num, den and clamped frac.
  - Form X = num << (frac+1), ITER = NUM_W+FRAC_MAX+1 bits wide (33 at defaults).
  - Clear remainder R (DEN_W+1 bits), quotient Q (ITER bits) and counter; busy=1.
  - If den==0, go to ROUND with sat flag set; otherwise go to RUN.
- RUN: one restoring step per cycle, MSB of X first.
  - R = {R, X[msb]}; shift X left.
  - If R >= den: R -= den, shift 1 into Q; else shift 0.
  - After exactly ITER steps, go to ROUND.
- ROUND:
  - Q is floor(num·2^(frac+1)/den), so Q[0] is the half-LSB bit.
  - T = (Q>>1) + Q[0], computed one bit wider than needed.
  - If sat, or T >= 2^OUT_W: result = all ones, ovf=1. Otherwise result = T[OUT_W-1:0], ovf=0.
  - done=1, busy=0, go to DONE.
- DONE: done=0, return to IDLE. Total one-cycle done pulse.
- Latency, with start sampled at edge k:
  - den≠0: done high after edge k+ITER+1 (k+34 at defaults).
  - den==0: done high after edge k+1.
- Handshake rules:
  - start while busy, or in DONE, is ignored; operands are not re-latched.
  - start held high through completion begins a new operation at the first edge in IDLE.
  - num, den and frac may change freely after acceptance.
- Output stability: result and ovf change only on a done edge or on reset.
- num==0 with den≠0: result=0, ovf=0, full latency.

Test Plan:
- num=1, frac=15, den=3, OUT_W=16 → result=0x2AAB, ovf=0; done exactly one cycle, 34 edges after start.
- num=0x0001, frac=8, den=3 → result=0x000055. Separately, num=5, frac=8, den=7 → result=0x0000B7 (182.86 rounds up).
- num=1, frac=0, den=2 → result=0x000001 (exact half rounds up). num=0, frac=8, den=9 → result=0, ovf=0.
- den=0 (any num) → result=0xFFFFFF, ovf=1, done after edge k+1. num=0xFFFF, frac=16, den=1 → result=0xFFFFFF, ovf=1.
- During a run (num=1, frac=15, den=3), pulse start with different operands at cycle 10 → ignored; result=0x002AAB, busy never drops early.
- Reset_n low at cycle 20 of a run → busy, done, result and ovf go to 0 immediately; no done pulse. A new start after release completes normally.
